mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Initiator side of the single-port block RAM interface (en/we/rst/addr/di/dout, 1-cycle registered read).
//  Accepts load/store requests from the core and issues word-addressed RAM cycles.
//  Provides byte/half/word access with sign/zero extension. Sub-word stores use read-modify-write
//  because the RAM has only a full-word write enable. Sits between the core's MEM stage and the RAM.
// PARAMETERS
//  ADDR_MASK  32'h000F_FFFC  byte-address mask applied to ram_addr (1 MiB RAM, word aligned)
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset; synchronous, active-high
//  req_valid    in   1   request present
//  req_ready    out  1   unit can accept a request this cycle
//  req_we       in   1   1=store, 0=load
//  req_size     in   2   00=byte, 01=half, 10/11=word
//  req_unsigned in   1   loads: 1=zero-extend, 0=sign-extend
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, LSB-aligned
//  resp_valid   out  1   one-cycle completion pulse (load data or store ack); no backpressure
//  resp_rdata   out  32  extended load data; 0 for stores
//  resp_err     out  1   misaligned access flag (see CONFIGURATION)
//  ram_en       out  1   RAM enable
//  ram_we       out  1   RAM write enable
//  ram_rst      out  1   RAM output reset; tied 0
//  ram_addr     out  32  byte address to RAM = req_addr & ADDR_MASK
//  ram_di       out  32  RAM write data
//  ram_dout     in   32  RAM read data, valid the cycle after ram_en with ram_we=0
// BEHAVIOUR
//  - Reset: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0; ram_en=ram_we=0 in reset cycle.
//  - rst mid-operation aborts: pending merge write is never issued; no resp_valid for the aborted op.
//  - Byte lanes little-endian: addr[1:0]=0 -> bits 7:0; half uses addr[1] (0 -> bits 15:0).
//  - req_ready=1 only in IDLE (and not in rst). Accept = req_valid & req_ready; addr/size/data latched.
//  - FSM states: IDLE, RD, MERGE.
//    IDLE, load accepted: ram_en=1, ram_we=0 -> RD.
//    IDLE, word store:    ram_en=1, ram_we=1, ram_di=req_wdata; stay IDLE; resp_valid next cycle.
//    IDLE, sub-word store: ram_en=1, ram_we=0 (read old word) -> MERGE.
//    RD:    select lane from ram_dout, extend, register into resp_rdata; resp_valid next cycle; -> IDLE.
//    MERGE: ram_en=1, ram_we=1, ram_di=ram_dout with target lane replaced by wdata[7:0]/[15:0];
//           resp_valid next cycle; -> IDLE.
//  - Latency from accept (cycle 0): load resp cycle 2; word store resp cycle 1; sub-word store resp
//    cycle 2. req_ready reasserts in the resp_valid cycle, so back-to-back word stores run 1/cycle.
//  - Outside RD/MERGE/accept cycles ram_en=0. resp_valid is high for exactly one cycle per op.
//  - Read-first RAM: merge read and later write to same word never overlap (single op in flight).
// CONFIGURATION
//  MAU_MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 is accepted,
//   issues no RAM cycle, and gives resp_valid=1, resp_err=1, resp_rdata=0 the next cycle.
//  Undefined: resp_err tied 0; word ignores addr[1:0], half ignores addr[0] (aligned down).
// TESTING
//  1. RAM[0x100]=0x8844_22F0; LB 0x101 signed -> cycle 2 resp_rdata=0x0000_0022.
//  2. Same word; LB 0x103 signed -> 0xFFFF_FF88; LBU 0x103 -> 0x0000_0088; LH 0x102 -> 0xFFFF_8844.
//  3. SB 0x102 data 0xAB on 0x8844_22F0 -> ram_we only in cycle 1 with ram_di=0x88AB_22F0;
//     following LW 0x100 returns 0x88AB_22F0.
//  4. Four SW back-to-back 0x0,0x4,0x8,0xC data 1..4 -> ram_we high 4 consecutive cycles,
//     4 resp_valid pulses, req_ready never low; LW each returns 1..4.
//  5. SH 0x200 accepted, rst asserted in MERGE cycle -> no ram_we, no resp_valid; RAM[0x200] unchanged,
//     post-reset req_ready=1, resp_rdata=0.
//  6. With MAU_MISALIGN_CHECK_EN: LW 0x102 -> ram_en stays 0, resp_err=1, resp_rdata=0 at cycle 1;
//     without it: LW 0x102 returns word at 0x100.

Source files
------------

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Initiator for a single-port block RAM with a 1-cycle registered read
//   (en/we/rst/addr/di/dout). It takes load/store requests from the core's
//   MEM stage and issues word-addressed RAM cycles.
//   - Byte, half and word accesses. Lanes are little-endian.
//   - Loads are sign- or zero-extended.
//   - The RAM has only a full-word write enable, so sub-word stores use a
//     read-modify-write sequence.
//   - Only one operation is in flight at a time.
//
// Optional feature (macro MAU_MISALIGN_CHECK_EN):
//   defined   : a misaligned half or word access is accepted but issues no
//               RAM cycle. The next cycle gives resp_valid=1, resp_err=1 and
//               resp_rdata=0.
//   undefined : resp_err is always 0. Misaligned halves and words are
//               aligned down.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   req_valid/ready     request handshake (ready only in IDLE, not in reset)
//   req_we              1=store, 0=load
//   req_size            00=byte, 01=half, 1x=word
//   req_unsigned        loads: 1=zero-extend, 0=sign-extend
//   req_addr            byte address
//   req_wdata           store data, LSB-aligned
//   resp_valid          one-cycle completion pulse (no backpressure)
//   resp_rdata          extended load data, 0 for stores
//   resp_err            misaligned-access flag
//   ram_en/we/rst       RAM controls (ram_rst tied low)
//   ram_addr            req_addr & ADDR_MASK
//   ram_di, ram_dout    RAM write / read data
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter logic [31:0] ADDR_MASK = 32'h000F_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        ram_en,
  output logic        ram_we,
  output logic        ram_rst,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_di,
  input  logic [31:0] ram_dout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD    = 2'd1,
    S_MERGE = 2'd2
  } state_t;

  state_t      state_q, state_d;

  // Request fields latched on accept
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [15:0] wdata_q;

  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        accept;
  logic        misalign;

  // Select the addressed lane from a RAM word and extend it to 32 bits.
  // For halves only lo[1] matters; words ignore lo.
  function automatic logic [31:0] load_extend(
    input logic [31:0] word,
    input logic [1:0]  lo,
    input logic [1:0]  size,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed byte or half of the old word with new store data.
  function automatic logic [31:0] merge_lane(
    input logic [31:0] word,
    input logic [15:0] wdata,
    input logic [1:0]  lo,
    input logic [1:0]  size
  );
    logic [31:0] m;
    m = word;
    if (size == 2'b00) begin
      case (lo)
        2'd0:    m[7:0]   = wdata[7:0];
        2'd1:    m[15:8]  = wdata[7:0];
        2'd2:    m[23:16] = wdata[7:0];
        default: m[31:24] = wdata[7:0];
      endcase
    end else if (lo[1]) begin
      m[31:16] = wdata;
    end else begin
      m[15:0] = wdata;
    end
    return m;
  endfunction

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

`ifdef MAU_MISALIGN_CHECK_EN
  assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                    (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // ---- FSM state register ----
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---- FSM next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && !misalign) begin
          if (!req_we)          state_d = S_RD;
          else if (!req_size[1]) state_d = S_MERGE;
        end
      end
      S_RD:    state_d = S_IDLE;
      S_MERGE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- FSM outputs: RAM cycle and next response ----
  always_comb begin
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_di       = 32'h0;
    ram_addr     = ((state_q == S_IDLE) ? req_addr : addr_q) & ADDR_MASK;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (misalign) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            // Load and sub-word store both read here. Only a word store
            // writes directly.
            ram_en = 1'b1;
            if (req_we && req_size[1]) begin
              ram_we       = 1'b1;
              ram_di       = req_wdata;
              resp_valid_d = 1'b1;
            end
          end
        end
      end
      S_RD: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = load_extend(ram_dout, addr_q[1:0], size_q, uns_q);
      end
      S_MERGE: begin
        ram_en       = 1'b1;
        ram_we       = 1'b1;
        ram_di       = merge_lane(ram_dout, wdata_q, addr_q[1:0], size_q);
        resp_valid_d = 1'b1;
      end
      default: ;
    endcase
    // A reset cycle must not touch the RAM. This also drops a pending merge
    // write.
    if (rst) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

  assign ram_rst = 1'b0;

  // ---- Request capture (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      wdata_q <= req_wdata[15:0];
    end
  end

  // ---- Response register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_en;
  logic        ram_we;
  logic        ram_rst;
  logic [31:0] ram_addr;
  logic [31:0] ram_di;
  logic [31:0] ram_dout;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_rst      (ram_rst),
    .ram_addr     (ram_addr),
    .ram_di       (ram_di),
    .ram_dout     (ram_dout)
  );

  // Single-port RAM, 1-cycle registered read, read-first, 4 KiB window
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr[11:2]] <= ram_di;
      else        ram_dout <= mem[ram_addr[11:2]];
    end
  end

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int nresp = 0;
  int resp_cyc = 0;
  int nwe = 0;
  int we_cyc = 0;
  int last_c0 = 0;
  logic [31:0] we_di = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Record RAM write activity of the current cycle (inputs already settled)
  task automatic samp();
    if (ram_we === 1'b1) begin
      nwe++;
      we_cyc = cyc;
      we_di  = ram_di;
    end
  endtask

  // Advance one clock and pop/compare any response that appears
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (resp_valid === 1'b1) begin
      nresp++;
      resp_cyc = cyc;
      if (sb.size() == 0) begin
        chk("resp_expected", 32'(sb.size() > 0), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  endtask

  task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_lat, input logic exp_en0);
    int r0;
    int n;
    sb.push_back({exp_err, exp_rdata});
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    #1;
    chk("req_ready", 32'(req_ready), 32'd1);
    chk("ram_en_accept", 32'(ram_en), 32'(exp_en0));
    if (exp_en0) chk("ram_addr", ram_addr, addr & 32'h000F_FFFC);
    last_c0 = cyc;
    r0  = nresp;
    nwe = 0;
    samp();
    tick();
    req_valid = 1'b0;
    n = 0;
    while (nresp == r0 && n < 8) begin
      #1;
      samp();
      tick();
      n++;
    end
    chk("resp_count", 32'(nresp - r0), 32'd1);
    chk("latency", 32'(resp_cyc - last_c0), 32'(exp_lat));
  endtask

  initial begin
    int nr;
    int r0;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;

    // Reset state
    repeat (3) tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("ram_rst", 32'(ram_rst), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Preload with word stores (response 1 cycle after accept)
    do_op(1'b1, 2'b10, 1'b0, 32'h100, 32'h8844_22F0, 32'h0, 1'b0, 1, 1'b1);
    do_op(1'b1, 2'b10, 1'b0, 32'h200, 32'h1234_5678, 32'h0, 1'b0, 1, 1'b1);
    do_op(1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFE_F00D, 32'h0, 1'b0, 1, 1'b1);

    // Loads with lane select and extension
    do_op(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h0000_0022, 1'b0, 2, 1'b1);
    do_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hFFFF_FF88, 1'b0, 2, 1'b1);
    do_op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h0000_0088, 1'b0, 2, 1'b1);
    do_op(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'hFFFF_FFF0, 1'b0, 2, 1'b1);
    do_op(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFF_8844, 1'b0, 2, 1'b1);
    do_op(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h0000_8844, 1'b0, 2, 1'b1);
    do_op(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'h0000_22F0, 1'b0, 2, 1'b1);
    do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h8844_22F0, 1'b0, 2, 1'b1);

    // SB read-modify-write: single write in cycle 1 with merged data
    do_op(1'b1, 2'b00, 1'b0, 32'h102, 32'h1234_56AB, 32'h0, 1'b0, 2, 1'b1);
    chk("sb_we_count", 32'(nwe), 32'd1);
    chk("sb_we_cycle", 32'(we_cyc - last_c0), 32'd1);
    chk("sb_we_di", we_di, 32'h88AB_22F0);
    do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h88AB_22F0, 1'b0, 2, 1'b1);

    // SH upper half
    do_op(1'b1, 2'b01, 1'b0, 32'h302, 32'hFFFF_1357, 32'h0, 1'b0, 2, 1'b1);
    chk("sh_we_di", we_di, 32'h1357_F00D);
    do_op(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h1357_F00D, 1'b0, 2, 1'b1);

    // Misaligned accesses
`ifdef MAU_MISALIGN_CHECK_EN
    do_op(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1, 1'b0);
    chk("mis_lw_no_we", 32'(nwe), 32'd0);
    do_op(1'b1, 2'b01, 1'b0, 32'h101, 32'h5555, 32'h0, 1'b1, 1, 1'b0);
    chk("mis_sh_no_we", 32'(nwe), 32'd0);
    do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h88AB_22F0, 1'b0, 2, 1'b1);
`else
    do_op(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h88AB_22F0, 1'b0, 2, 1'b1);
    do_op(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 32'hFFFF_88AB, 1'b0, 2, 1'b1);
`endif

    // Back-to-back word stores, one per cycle
    nwe = 0;
    nr  = 0;
    r0  = nresp;
    for (int i = 0; i < 4; i++) begin
      req_valid    = 1'b1;
      req_we       = 1'b1;
      req_size     = 2'b10;
      req_unsigned = 1'b0;
      req_addr     = 32'(4 * i);
      req_wdata    = 32'(i + 1);
      sb.push_back({1'b0, 32'h0});
      #1;
      if (req_ready !== 1'b1) nr++;
      samp();
      tick();
    end
    req_valid = 1'b0;
    repeat (2) begin
      #1;
      samp();
      tick();
    end
    chk("b2b_we_count", 32'(nwe), 32'd4);
    chk("b2b_resp_count", 32'(nresp - r0), 32'd4);
    chk("b2b_ready_low", 32'(nr), 32'd0);
    for (int i = 0; i < 4; i++)
      do_op(1'b0, 2'b10, 1'b0, 32'(4 * i), 32'h0, 32'(i + 1), 1'b0, 2, 1'b1);

    // Reset during MERGE aborts the store
    nwe = 0;
    r0  = nresp;
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = 2'b01;
    req_unsigned = 1'b0;
    req_addr     = 32'h200;
    req_wdata    = 32'h0000_BEEF;
    #1;
    samp();
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_ram_we", 32'(ram_we), 32'd0);
    chk("abort_ram_en", 32'(ram_en), 32'd0);
    samp();
    tick();
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_rdata", resp_rdata, 32'h0);
    samp();
    repeat (2) begin
      tick();
      #1;
      samp();
    end
    chk("abort_resp_count", 32'(nresp - r0), 32'd0);
    chk("abort_we_count", 32'(nwe), 32'd0);
    do_op(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h1234_5678, 1'b0, 2, 1'b1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
